bp_fe_pred_write_sched: RTL

Write-port scheduler for the front-end branch predictor tables (BTB or BHT). It sits between pc_gen's update sources and a single-ported predictor table. It merges redirect-driven corrections and attaboy confirmations into one write stream, buffers attaboys, and prevents their starvation. It also sequences the table clear sweep after reset and on flush.

---
 rtl/bp_fe_pred_write_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bp_fe_pred_write_sched.sv
// Write-port scheduler for a single-ported branch predictor table: clears the table
// after reset/flush, then merges redirect corrections and buffered attaboys into one write stream.
module bp_fe_pred_write_sched #(
  parameter int els_p          = 64,
  parameter int idx_width_p    = $clog2(els_p),
  parameter int data_width_p   = 32,
  parameter int fifo_els_p     = 4,
  parameter int starve_limit_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    flush_i,
  output logic                    init_done_o,
  input  logic                    redirect_v_i,
  input  logic [idx_width_p-1:0]  redirect_idx_i,
  input  logic [data_width_p-1:0] redirect_data_i,
  output logic                    redirect_ovw_o,
  input  logic                    attaboy_v_i,
  input  logic [idx_width_p-1:0]  attaboy_idx_i,
  input  logic [data_width_p-1:0] attaboy_data_i,
  output logic                    attaboy_ready_o,
  output logic                    w_v_o,
  output logic                    w_clr_o,
  output logic [idx_width_p-1:0]  w_idx_o,
  output logic [data_width_p-1:0] w_data_o,
  input  logic                    w_yumi_i
);

  // Handshakes: an attaboy transfers on attaboy_v_i & attaboy_ready_o; a table write
  // transfers on w_v_o & w_yumi_i, and only then is the granted source removed.

  localparam int ptr_w    = $clog2(fifo_els_p);
  localparam int cnt_w    = ptr_w + 1;
  localparam int starve_w = $clog2(starve_limit_p + 1);

  localparam logic [idx_width_p-1:0] last_idx   = idx_width_p'(els_p - 1);
  localparam logic [idx_width_p-1:0] idx_one    = idx_width_p'(1);
  localparam logic [ptr_w-1:0]       ptr_one    = ptr_w'(1);
  localparam logic [cnt_w-1:0]       cnt_one    = cnt_w'(1);
  localparam logic [cnt_w-1:0]       cnt_full   = cnt_w'(fifo_els_p);
  localparam logic [starve_w-1:0]    starve_one = starve_w'(1);
  localparam logic [starve_w-1:0]    starve_max = starve_w'(starve_limit_p);

  typedef enum logic {
    sweep_s = 1'b0,
    ready_s = 1'b1
  } state_e;

  state_e                  state;
  logic [idx_width_p-1:0]  sweep_cnt;
  logic [idx_width_p-1:0]  fifo_idx  [fifo_els_p];
  logic [data_width_p-1:0] fifo_data [fifo_els_p];
  logic [ptr_w-1:0]        rd_ptr;
  logic [ptr_w-1:0]        wr_ptr;
  logic [cnt_w-1:0]        fifo_cnt;
  logic                    rdr_v;
  logic [idx_width_p-1:0]  rdr_idx;
  logic [data_width_p-1:0] rdr_data;
  logic [starve_w-1:0]     starve_cnt;
  logic                    ovw_r;

  logic is_ready;
  logic fifo_empty;
  logic fifo_full;
  logic starved;
  logic grant_fifo;
  logic grant_rdr;
  logic pop;
  logic rdr_take;
  logic push;

  assign is_ready   = (state == ready_s);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == cnt_full);
  assign starved    = (starve_cnt == starve_max);

  // The redirect normally wins; a head that has lost starve_limit_p times is forced through.
  assign grant_fifo = is_ready & ~fifo_empty & (starved | ~rdr_v);
  assign grant_rdr  = is_ready & rdr_v & ~grant_fifo;
  assign pop        = grant_fifo & w_yumi_i;
  assign rdr_take   = grant_rdr & w_yumi_i;
  assign push       = attaboy_v_i & attaboy_ready_o;

  assign init_done_o     = is_ready;
  assign attaboy_ready_o = is_ready & ~fifo_full;
  assign redirect_ovw_o  = ovw_r;
  assign w_v_o           = reset_n_i & (~is_ready | rdr_v | ~fifo_empty);
  assign w_clr_o         = ~is_ready;
  assign w_idx_o         = ~is_ready  ? sweep_cnt :
                           grant_fifo ? fifo_idx[rd_ptr] : rdr_idx;
  assign w_data_o        = ~is_ready  ? '0 :
                           grant_fifo ? fifo_data[rd_ptr] : rdr_data;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= attaboy_idx_i;
      fifo_data[wr_ptr] <= attaboy_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= sweep_s;
      sweep_cnt  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      rdr_v      <= 1'b0;
      rdr_idx    <= '0;
      rdr_data   <= '0;
      starve_cnt <= '0;
      ovw_r      <= 1'b0;
    end else begin
      ovw_r <= 1'b0;
      case (state)
        sweep_s: begin
          if (flush_i) begin
            sweep_cnt <= '0;
          end else if (w_yumi_i) begin
            if (sweep_cnt == last_idx) begin
              state     <= ready_s;
              sweep_cnt <= '0;
            end else begin
              sweep_cnt <= sweep_cnt + idx_one;
            end
          end
        end
        ready_s: begin
          if (flush_i) begin
            state      <= sweep_s;
            sweep_cnt  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_cnt   <= '0;
            rdr_v      <= 1'b0;
            starve_cnt <= '0;
          end else begin
            if (push) wr_ptr <= wr_ptr + ptr_one;
            if (pop)  rd_ptr <= rd_ptr + ptr_one;
            case ({push, pop})
              2'b10:   fifo_cnt <= fifo_cnt + cnt_one;
              2'b01:   fifo_cnt <= fifo_cnt - cnt_one;
              default: fifo_cnt <= fifo_cnt;
            endcase
            // A newer redirect always replaces the register; it is an overwrite only if
            // the older one was still waiting.
            if (redirect_v_i) begin
              rdr_v    <= 1'b1;
              rdr_idx  <= redirect_idx_i;
              rdr_data <= redirect_data_i;
              ovw_r    <= rdr_v & ~rdr_take;
            end else if (rdr_take) begin
              rdr_v <= 1'b0;
            end
            if (fifo_empty || pop) begin
              starve_cnt <= '0;
            end else if (!grant_fifo && !starved) begin
              starve_cnt <= starve_cnt + starve_one;
            end
          end
        end
        default: state <= sweep_s;
      endcase
    end
  end

endmodule
